// File: rtl/alu_seq_driver_pkg.sv
// Shared types and constants for the byte-serial ALU sequencer.
package alu_drv_pkg;

  localparam int ALU_BYTE_W = 8;

  // Opcodes 0 and 1 are the add/subtract family that ripple carry across bytes.
  localparam logic [7:0] CARRY_OPS_DEFAULT = 8'b0000_0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_drv_state_t;

endpackage

// File: rtl/alu_seq_driver_if.sv
// Command/response bus between a command source (master) and alu_seq_driver (slave).
interface alu_seq_driver_if #(
  parameter int MAX_BYTES = 4
) ();
  import alu_drv_pkg::*;

  localparam int W  = ALU_BYTE_W * MAX_BYTES;
  localparam int LW = $clog2(MAX_BYTES);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_oper;
  logic [W-1:0]  cmd_a;
  logic [W-1:0]  cmd_b;
  logic          cmd_c_in;
  logic [LW-1:0] cmd_len;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_sum;
  logic          rsp_c_out;

  modport master (
    output cmd_valid, cmd_oper, cmd_a, cmd_b, cmd_c_in, cmd_len, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_sum, rsp_c_out
  );

  modport slave (
    input  cmd_valid, cmd_oper, cmd_a, cmd_b, cmd_c_in, cmd_len, rsp_ready,
    output cmd_ready, rsp_valid, rsp_sum, rsp_c_out
  );

endinterface

// File: rtl/alu_seq_driver.sv
// Feeds multi-byte commands to an 8-bit combinational ALU one byte per cycle, LSB first.
//   state | meaning
//   IDLE  | cmd_ready high, waiting for a command
//   EXEC  | driving byte idx to the ALU, capturing its result at each edge
//   RESP  | rsp_valid high, result held until rsp_ready
module alu_seq_driver
  import alu_drv_pkg::*;
#(
  parameter int         MAX_BYTES = 4,
  parameter logic [7:0] CARRY_OPS = CARRY_OPS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_seq_driver_if.slave       bus,
  output logic [2:0]            alu_oper,
  output logic [ALU_BYTE_W-1:0] alu_a,
  output logic [ALU_BYTE_W-1:0] alu_b,
  output logic                  alu_c_in,
  input  logic [ALU_BYTE_W-1:0] alu_sum,
  input  logic [ALU_BYTE_W-1:0] alu_c_out
);

  localparam int LW = $clog2(MAX_BYTES);

  alu_drv_state_t state_q, state_d;

  logic                                  ready_q;
  logic [LW-1:0]                         idx_q, len_q, len_in, idx_nx;
  logic [2:0]                            oper_q;
  logic                                  c_in_q, carry_q;
  logic [MAX_BYTES-1:0][ALU_BYTE_W-1:0]  a_q, b_q, sum_q;
  logic                                  accept, last, chain_c;
  logic                                  unused_c_out;

  // Lengths beyond the operand width only exist when MAX_BYTES is not a power of two.
  if (MAX_BYTES == (1 << LW)) begin : g_no_clamp
    assign len_in = bus.cmd_len;
  end else begin : g_clamp
    assign len_in = (bus.cmd_len > LW'(MAX_BYTES - 1)) ? LW'(MAX_BYTES - 1) : bus.cmd_len;
  end

  assign last         = (idx_q == len_q);
  assign idx_nx       = idx_q + LW'(1);
  assign chain_c      = CARRY_OPS[oper_q] ? alu_c_out[0] : c_in_q;
  assign unused_c_out = ^alu_c_out[ALU_BYTE_W-1:1];

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && ready_q) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (last) state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU drive is registered: the next byte is launched on the edge that captures the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      idx_q    <= '0;
      len_q    <= '0;
      oper_q   <= '0;
      c_in_q   <= 1'b0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      alu_oper <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_c_in <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      if (accept) begin
        oper_q   <= bus.cmd_oper;
        a_q      <= bus.cmd_a;
        b_q      <= bus.cmd_b;
        c_in_q   <= bus.cmd_c_in;
        len_q    <= len_in;
        idx_q    <= '0;
        sum_q    <= '0;
        carry_q  <= 1'b0;
        alu_oper <= bus.cmd_oper;
        alu_a    <= bus.cmd_a[ALU_BYTE_W-1:0];
        alu_b    <= bus.cmd_b[ALU_BYTE_W-1:0];
        alu_c_in <= bus.cmd_c_in;
      end else if (state_q == EXEC) begin
        sum_q[idx_q] <= alu_sum;
        carry_q      <= alu_c_out[0];
        if (!last) begin
          idx_q    <= idx_nx;
          alu_a    <= a_q[idx_nx];
          alu_b    <= b_q[idx_nx];
          alu_c_in <= chain_c;
        end
      end
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_c_out = carry_q;

endmodule

// File: tb/tb_alu_seq_driver.sv
// Directed bench for alu_seq_driver: a behavioural ALU, a response scoreboard and per-byte drive checks.
module tb_alu_seq_driver;

  localparam int MAX_BYTES = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] alu_oper;
  logic [7:0] alu_a, alu_b, alu_sum, alu_c_out;
  logic       alu_c_in;
  logic [8:0] alu_r;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [31:0] sum;
    logic        c;
    string       tag;
  } exp_t;

  exp_t sb[$];

  alu_seq_driver_if #(.MAX_BYTES(MAX_BYTES)) bus ();

  alu_seq_driver #(.MAX_BYTES(MAX_BYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .alu_oper  (alu_oper),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c_in  (alu_c_in),
    .alu_sum   (alu_sum),
    .alu_c_out (alu_c_out)
  );

  always #5 clk = ~clk;

  // oper 0: add with carry, oper 2: and, anything else: xor; carry bits [7:1] are junk on purpose
  function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic c);
    case (op)
      3'd0:    ref_alu = {1'b0, a} + {1'b0, b} + {8'd0, c};
      3'd2:    ref_alu = {1'b0, a & b};
      default: ref_alu = {1'b0, a ^ b};
    endcase
  endfunction

  assign alu_r     = ref_alu(alu_oper, alu_a, alu_b, alu_c_in);
  assign alu_sum   = alu_r[7:0];
  assign alu_c_out = {7'h55, alu_r[8]};

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void check_zero(input string tag);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_sum"},   bus.rsp_sum,        32'd0);
    check({tag, "_rsp_c_out"}, 32'(bus.rsp_c_out), 32'd0);
    check({tag, "_alu_oper"},  32'(alu_oper),      32'd0);
    check({tag, "_alu_a"},     32'(alu_a),         32'd0);
    check({tag, "_alu_b"},     32'(alu_b),         32'd0);
    check({tag, "_alu_c_in"},  32'(alu_c_in),      32'd0);
  endfunction

  // Response monitor: every handshake must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_rsp: got sum %0h with nothing outstanding", bus.rsp_sum);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_rsp_sum"},   bus.rsp_sum,        e.sum);
          check({e.tag, "_rsp_c_out"}, 32'(bus.rsp_c_out), 32'(e.c));
        end
      end
    end
  end

  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic cin, input int len,
                       input logic [31:0] exp_sum, input logic exp_c, input bit push);
    exp_t e;
    bus.cmd_oper  = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_c_in  = cin;
    bus.cmd_len   = 2'(len);
    bus.cmd_valid = 1'b1;
    if (push) begin
      e.sum = exp_sum;
      e.c   = exp_c;
      e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic wait_accept(input string tag, output int waited);
    waited = 0;
    while (!bus.cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_accept"}, 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  // Called right after the accept edge; checks each byte on the ALU port and the response latency.
  task automatic wait_rsp(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic cin, input int len);
    int         lat;
    logic       c_cur;
    logic [8:0] r;
    lat   = 0;
    c_cur = cin;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid || lat > 10) break;
      if (lat <= len) begin
        check({tag, "_alu_oper"}, 32'(alu_oper), 32'(op));
        check({tag, "_alu_a"},    32'(alu_a),    32'(a[8*lat +: 8]));
        check({tag, "_alu_b"},    32'(alu_b),    32'(b[8*lat +: 8]));
        check({tag, "_alu_c_in"}, 32'(alu_c_in), 32'(c_cur));
        r     = ref_alu(op, a[8*lat +: 8], b[8*lat +: 8], c_cur);
        c_cur = (op == 3'd0 || op == 3'd1) ? r[8] : cin;
      end
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(len + 1));
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic cin, input int len,
                     input logic [31:0] exp_sum, input logic exp_c);
    int w;
    issue(tag, op, a, b, cin, len, exp_sum, exp_c, 1'b1);
    wait_accept(tag, w);
    wait_rsp(tag, op, a, b, cin, len);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_oper  = 3'd5;
    bus.cmd_a     = 32'hDEAD_BEEF;
    bus.cmd_b     = 32'h1234_5678;
    bus.cmd_c_in  = 1'b1;
    bus.cmd_len   = 2'd3;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_zero("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 32'(bus.cmd_ready), 32'd1);

    // Abort a 4-byte op mid-EXEC; no response may follow.
    issue("abort", 3'd0, 32'h0102_0304, 32'h1111_1111, 1'b0, 3, 32'd0, 1'b0, 1'b0);
    wait_accept("abort", w);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("rst_mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end

    run("add1",    3'd0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 32'h0000_0000, 1'b1);
    run("add4",    3'd0, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 3, 32'h0100_0000, 1'b0);
    run("and4",    3'd2, 32'hF0F0_F0F0, 32'hFFFF_00FF, 1'b1, 3, 32'hF0F0_00F0, 1'b0);
    run("partial", 3'd0, 32'hAAAA_1234, 32'h5555_0001, 1'b0, 1, 32'h0000_1235, 1'b0);
    run("add1_ci", 3'd0, 32'h0000_007F, 32'h0000_0000, 1'b1, 0, 32'h0000_0080, 1'b0);
    run("add4_ci", 3'd0, 32'h1234_5678, 32'h1111_1111, 1'b1, 3, 32'h2345_678A, 1'b0);

    // Backpressure: hold the response while a second command waits on cmd_valid.
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    issue("bp1", 3'd0, 32'h0012_FF80, 32'h0000_0180, 1'b0, 2, 32'h0013_0100, 1'b0, 1'b1);
    wait_accept("bp1", w);
    wait_rsp("bp1", 3'd0, 32'h0012_FF80, 32'h0000_0180, 1'b0, 2);
    issue("bp2", 3'd0, 32'h7FFF_FFFF, 32'h8000_0001, 1'b0, 3, 32'h0000_0000, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_hold_sum",   bus.rsp_sum,        32'h0013_0100);
      check("bp_hold_c_out", 32'(bus.rsp_c_out), 32'd0);
      check("bp_hold_ready", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_turn_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_turn_ready", 32'(bus.cmd_ready), 32'd1);
    wait_accept("bp2", w);
    check("bp2_accept_delay", 32'(w), 32'd0);
    wait_rsp("bp2", 3'd0, 32'h7FFF_FFFF, 32'h8000_0001, 1'b0, 3);

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_seq_driver.md
# alu_seq_driver

Sequential initiator for the team's 8-bit combinational `ALU` (`oper[2:0]`, `a[7:0]`, `b[7:0]`, `c_in` in; `sum[7:0]`, `c_out[7:0]` out).
- Accepts multi-byte operation commands over a valid/ready interface.
- Issues them to the ALU one byte per cycle, LSB first, chaining carry between bytes where the opcode requires it.
- Returns the assembled result over a valid/ready response interface.
- Sits between a command source (CPU/test sequencer) and one `ALU` instance in the integration top.

## Interface
Parameters:
- `MAX_BYTES`, 4, maximum operand length in bytes (≥2); `W = 8*MAX_BYTES`, `LW = $clog2(MAX_BYTES)`.
- `CARRY_OPS`, 8'b0000_0011, bit k set: opcode k chains carry between bytes.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  rising-edge clock.
  - `rst`  in  1  asynchronous, active-high reset.
- Command interface:
  - `cmd_valid`  in  1  command present.
  - `cmd_ready`  out  1  block can accept a command.
  - `cmd_oper`  in  3  ALU opcode.
  - `cmd_a`, `cmd_b`  in  W  operands; byte 0 = bits [7:0].
  - `cmd_c_in`  in  1  initial carry-in.
  - `cmd_len`  in  LW  operand bytes minus one.
- ALU-facing signals:
  - `alu_oper`  out  3  to ALU `oper`.
  - `alu_a`, `alu_b`  out  8  to ALU `a`, `b`.
  - `alu_c_in`  out  1  to ALU `c_in`.
  - `alu_sum`  in  8  from ALU `sum`.
  - `alu_c_out`  in  8  from ALU `c_out`; bit 0 is carry, bits [7:1] ignored.
- Response interface:
  - `rsp_valid`  out  1  result present.
  - `rsp_ready`  in  1  consumer accepts result.
  - `rsp_sum`  out  W  assembled result.
  - `rsp_c_out`  out  1  carry of last byte.

## Operation
FSM states: IDLE, EXEC, RESP.

IDLE
- `cmd_ready`=1.
- On `cmd_valid && cmd_ready`: latch oper, a, b, c_in, len.
- Set byte index `idx`=0, clear `rsp_sum`, go to EXEC.

EXEC
- Per-byte ALU drive:
  - `alu_oper` = latched oper.
  - `alu_a`/`alu_b` = byte `idx` of the latched operands.
  - `alu_c_in`: byte 0 = `cmd_c_in`. For byte `idx`>0 it is the captured carry if `CARRY_OPS[oper]`, else `cmd_c_in`.
- Capture and advance:
  - At each edge, capture `alu_sum` into `rsp_sum` byte `idx` and `alu_c_out[0]` into the carry register.
  - If `idx==len`, go to RESP; else `idx`+1.
- ALU-facing outputs are registered. They update at the same edge that advances `idx`, so the ALU's combinational result is stable for a full cycle before capture.

RESP
- `rsp_valid`=1, `rsp_c_out` = last captured carry.
- `rsp_sum` bytes above `len` are 0.
- On `rsp_ready`: go to IDLE.

Boundary rules:
- `cmd_len` ≥ `MAX_BYTES` (non-power-of-2 `MAX_BYTES`) is clamped to `MAX_BYTES-1`.
- `cmd_valid` is ignored outside IDLE. Commands are never queued.
- `rsp_sum` and `rsp_c_out` are held stable while `rsp_valid && !rsp_ready`.
- Reset asserted mid-operation aborts it with no partial response.

## Timing
- Reset values: `cmd_ready`=0 while `rst` is high, 1 in the first cycle after release. `rsp_valid`=0, `rsp_sum`=0, `rsp_c_out`=0, `alu_oper`=0, `alu_a`=0, `alu_b`=0, `alu_c_in`=0. State=IDLE, `idx`=0.
- For a command accepted at edge n:
  - `cmd_ready` drops after edge n.
  - Byte k is driven during cycle n+k to n+k+1 and captured at edge n+k+1.
  - `rsp_valid` rises after edge n+len+1.
- Latency: a 1-byte op gives the response 1 cycle after accept; a `MAX_BYTES` op gives it `MAX_BYTES` cycles after accept.
- Response handshake completes at edge m. `rsp_valid` falls and `cmd_ready` rises after m. The earliest next accept is edge m+1, so there is no same-cycle turnaround.
- Throughput: one command per len+3 cycles when the consumer is always ready.

## Structure
- Package `alu_drv_pkg` holds:
  - the state enum `alu_drv_state_t` (IDLE, EXEC, RESP);
  - `ALU_BYTE_W`=8;
  - the default `CARRY_OPS` constant.
- Single module, no sub-module. The integration top instantiates `ALU` alongside `alu_seq_driver` and wires the `alu_*` ports.

## Test plan
The bench ALU model uses oper 0 = a+b+c_in (carry out), oper 2 = a&b (carry 0).
- Reset: hold `rst` 3 cycles, then pulse `rst` mid-EXEC of a 4-byte op. All outputs are 0 during reset, no `rsp_valid` afterwards, and `cmd_ready`=1 one cycle after release.
- 1-byte add: oper 0, a=8'hFF, b=8'h01, c_in=0, len=0. `rsp_sum`=32'h0000_0000, `rsp_c_out`=1, `rsp_valid` 1 cycle after accept.
- 4-byte chained add: a=32'h00FF_FFFF, b=32'h0000_0001, c_in=0, len=3. `rsp_sum`=32'h0100_0000, `rsp_c_out`=0, `rsp_valid` 4 cycles after accept.
- Non-chained op: oper 2, a=32'hF0F0_F0F0, b=32'hFFFF_00FF, c_in=1, len=3. `rsp_sum`=32'hF0F0_00F0, and `alu_c_in`=1 on every byte.
- Backpressure: hold `rsp_ready`=0 for 5 cycles with `cmd_valid` held high. The response stays stable, `cmd_ready` stays 0, and the second command is accepted exactly 1 cycle after the response handshake.
- Partial length: len=1, a=32'hAAAA_1234, b=32'h5555_0001. `rsp_sum`=32'h0000_1235 (upper bytes zero).
